// File: rtl/time_set_rx.sv
// UART time-setting receiver: accepts "T" + YYYYMMDDhhmmss + CR frames at 8N1,
// range-checks the date/time and loads it into packed-BCD time fields.
module time_set_rx #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic       load,
  output logic       err,
  output logic       busy,
  output logic [6:0] second,
  output logic [6:0] minute,
  output logic [5:0] hour,
  output logic [5:0] day,
  output logic [4:0] month,
  output logic [7:0] year_l,
  output logic [7:0] year_h
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int CNT_W = $clog2(DIV + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);

  localparam logic [7:0] CHAR_T  = 8'h54;
  localparam logic [7:0] CHAR_CR = 8'h0D;

  // ---------------------------------------------------------------------------
  // Input synchronizer (idles high so reset does not look like a start bit)
  // ---------------------------------------------------------------------------
  logic sync1;
  logic rx_s;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      rx_s  <= sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Byte receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  rx_state_t        rx_state;
  rx_state_t        rx_state_next;
  logic [CNT_W-1:0] rx_cnt;
  logic [CNT_W-1:0] rx_cnt_next;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_next;
  logic [7:0]       rx_shift;
  logic [7:0]       rx_shift_next;
  logic             byte_stb;
  logic             frame_err;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      bit_idx  <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_next;
      rx_cnt   <= rx_cnt_next;
      bit_idx  <= bit_idx_next;
      rx_shift <= rx_shift_next;
    end
  end

  // byte_stb and frame_err are asserted in the cycle the stop bit is sampled
  always_comb begin
    rx_state_next = rx_state;
    rx_cnt_next   = rx_cnt + 1'b1;
    bit_idx_next  = bit_idx;
    rx_shift_next = rx_shift;
    byte_stb      = 1'b0;
    frame_err     = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_next = '0;
        if (!rx_s) rx_state_next = RX_START;
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_next   = '0;
          bit_idx_next  = '0;
          rx_state_next = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_next   = '0;
          rx_shift_next = {rx_s, rx_shift[7:1]};
          if (bit_idx == 3'd7) rx_state_next = RX_STOP;
          else                 bit_idx_next  = bit_idx + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_next   = '0;
          rx_state_next = RX_IDLE;
          if (rx_s) byte_stb  = 1'b1;
          else      frame_err = 1'b1;
        end
      end
      default: begin
        rx_state_next = RX_IDLE;
        rx_cnt_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame parser
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    P_WAIT_T,
    P_DIGITS,
    P_WAIT_CR
  } p_state_t;

  p_state_t         p_state;
  p_state_t         p_state_next;
  logic [3:0]       idx;
  logic [3:0]       idx_next;
  logic [13:0][3:0] shadow;
  logic             shadow_we;
  logic             commit;
  logic             busy_next;
  logic             load_next;
  logic             err_next;

  logic is_t;
  logic is_cr;
  logic is_digit;

  assign is_t     = (rx_shift == CHAR_T);
  assign is_cr    = (rx_shift == CHAR_CR);
  assign is_digit = (rx_shift >= 8'h30) && (rx_shift <= 8'h39);

  function automatic logic [6:0] dec2(input logic [3:0] tens, input logic [3:0] ones);
    return (7'(tens) * 7'd10) + 7'(ones);
  endfunction

  logic [6:0] month_v;
  logic [6:0] day_v;
  logic [6:0] hour_v;
  logic [6:0] minute_v;
  logic [6:0] second_v;
  logic       nibbles_ok;
  logic       range_ok;

  assign month_v  = dec2(shadow[4],  shadow[5]);
  assign day_v    = dec2(shadow[6],  shadow[7]);
  assign hour_v   = dec2(shadow[8],  shadow[9]);
  assign minute_v = dec2(shadow[10], shadow[11]);
  assign second_v = dec2(shadow[12], shadow[13]);

  always_comb begin
    nibbles_ok = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (shadow[i] > 4'd9) nibbles_ok = 1'b0;
    end
  end

  assign range_ok = nibbles_ok
                 && (month_v >= 7'd1) && (month_v <= 7'd12)
                 && (day_v   >= 7'd1) && (day_v   <= 7'd31)
                 && (hour_v   <= 7'd23)
                 && (minute_v <= 7'd59)
                 && (second_v <= 7'd59);

  // A 'T' always restarts the frame; anything unexpected mid-frame aborts it
  always_comb begin
    p_state_next = p_state;
    idx_next     = idx;
    shadow_we    = 1'b0;
    commit       = 1'b0;
    busy_next    = busy;
    load_next    = 1'b0;
    err_next     = 1'b0;
    if (byte_stb && is_t) begin
      p_state_next = P_DIGITS;
      idx_next     = '0;
      busy_next    = 1'b1;
    end else if (byte_stb || frame_err) begin
      case (p_state)
        P_DIGITS: begin
          if (byte_stb && is_digit) begin
            shadow_we = 1'b1;
            idx_next  = idx + 1'b1;
            if (idx == 4'd13) p_state_next = P_WAIT_CR;
          end else begin
            p_state_next = P_WAIT_T;
            idx_next     = '0;
            busy_next    = 1'b0;
            err_next     = 1'b1;
          end
        end
        P_WAIT_CR: begin
          p_state_next = P_WAIT_T;
          idx_next     = '0;
          busy_next    = 1'b0;
          if (byte_stb && is_cr && range_ok) begin
            load_next = 1'b1;
            commit    = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      p_state <= P_WAIT_T;
      idx     <= '0;
      shadow  <= '0;
      busy    <= 1'b0;
      load    <= 1'b0;
      err     <= 1'b0;
    end else begin
      p_state <= p_state_next;
      idx     <= idx_next;
      busy    <= busy_next;
      load    <= load_next;
      err     <= err_next;
      if (shadow_we) shadow[idx] <= rx_shift[3:0];
    end
  end

  // Time fields: only the committed, range-checked shadow ever reaches them
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      year_h <= 8'h20;
      year_l <= 8'h00;
      month  <= 5'h01;
      day    <= 6'h01;
      hour   <= 6'h00;
      minute <= 7'h00;
      second <= 7'h00;
    end else if (commit) begin
      year_h <= {shadow[0], shadow[1]};
      year_l <= {shadow[2], shadow[3]};
      month  <= {shadow[4][0],   shadow[5]};
      day    <= {shadow[6][1:0], shadow[7]};
      hour   <= {shadow[8][1:0], shadow[9]};
      minute <= {shadow[10][2:0], shadow[11]};
      second <= {shadow[12][2:0], shadow[13]};
    end
  end

endmodule
